// File: rtl/alu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// alu_muldiv_unit
//   Iterative multiply/divide unit that sits next to the single-cycle ALU.
//   A request is accepted with Start while Busy=0. The operation then takes
//   WIDTH iteration cycles plus one sign-fixup cycle, and finishes with a
//   one-cycle Done pulse. Results are held until the next completion.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for Start; operands are captured on the accept edge
//   RUN   | one shift-add (mul) or restoring-subtract (div) step per cycle
//   FIX   | apply result signs, register Hi/Lo/DivByZero
//   DONE  | Done pulse; a new Start is accepted here (back-to-back ops)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   Start      request, sampled only when Busy=0 (IDLE or DONE)
//   Op         00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   input1     multiplicand / dividend
//   input2     multiplier / divisor
//   Busy       high in RUN and FIX
//   Done       one-cycle pulse when Hi/Lo become valid
//   Hi         product upper half / remainder
//   Lo         product lower half / quotient
//   DivByZero  last completed op was a divide by zero
// ---------------------------------------------------------------------------
module alu_muldiv_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             DivByZero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [1:0]             op_q;
  logic                   sign_a;
  logic                   sign_b;
  logic                   b_zero;
  logic [WIDTH-1:0]       a_raw;
  // multiplicand for multiply, divisor for divide (both as magnitudes)
  logic [WIDTH-1:0]       opnd;
  // multiply: {partial product high, multiplier/product low}
  // divide:   {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0]     acc;
  logic [CNT_W-1:0]       cnt;

  logic                   is_div;
  logic                   is_signed;

  logic                   cap_sa;
  logic                   cap_sb;
  logic [WIDTH-1:0]       mag1;
  logic [WIDTH-1:0]       mag2;

  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         div_diff;
  logic [2*WIDTH-1:0]     div_next;

  logic [2*WIDTH-1:0]     prod_fix;
  logic [WIDTH-1:0]       quo_fix;
  logic [WIDTH-1:0]       rem_fix;
  logic [WIDTH-1:0]       res_hi;
  logic [WIDTH-1:0]       res_lo;
  logic                   res_dbz;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Operand capture: signed ops keep magnitudes plus sign bits. The magnitude
  // of -2^(WIDTH-1) is 2^(WIDTH-1), which is still correct read as unsigned.
  always_comb begin
    cap_sa = Op[0] & input1[WIDTH-1];
    cap_sb = Op[0] & input2[WIDTH-1];
    mag1   = cap_sa ? -input1 : input1;
    mag2   = cap_sb ? -input2 : input2;
  end

  // One iteration step for each algorithm.
  always_comb begin
    // shift-add: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole accumulator right with carry
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // restoring division: shift the next dividend bit into the remainder and
    // try subtracting the divisor; bit WIDTH of the difference is the borrow
    div_diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

  // Sign fixup and result selection for the FIX cycle.
  always_comb begin
    prod_fix = (is_signed && (sign_a ^ sign_b)) ? -acc : acc;
    quo_fix  = (is_signed && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    res_dbz  = 1'b0;
    if (is_div) begin
      if (b_zero) begin
        // divide by zero: all-ones quotient, dividend passed through raw
        res_hi  = a_raw;
        res_lo  = {WIDTH{1'b1}};
        res_dbz = 1'b1;
      end else begin
        res_hi  = rem_fix;
        res_lo  = quo_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      DivByZero <= 1'b0;
      op_q      <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      b_zero    <= 1'b0;
      a_raw     <= '0;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          Done <= 1'b0;
          if (Start) begin
            op_q   <= Op;
            sign_a <= cap_sa;
            sign_b <= cap_sb;
            b_zero <= (input2 == '0);
            a_raw  <= input1;
            if (Op[1]) begin
              opnd <= mag2;
              acc  <= {{WIDTH{1'b0}}, mag1};
            end else begin
              opnd <= mag1;
              acc  <= {{WIDTH{1'b0}}, mag2};
            end
            cnt   <= CNT_W'(WIDTH);
            Busy  <= 1'b1;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end

        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          Hi        <= res_hi;
          Lo        <= res_lo;
          DivByZero <= res_dbz;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          state     <= S_DONE;
        end

        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_unit
//   Directed-vector bench for alu_muldiv_unit (WIDTH=8). The stimulus task
//   pushes a hand-computed expected result when a request is accepted; an
//   independent monitor pops and compares on every Done pulse, also checking
//   latency from the accept edge and the length of the preceding Busy run.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_unit;

  localparam int WIDTH = 8;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             Start  = 1'b0;
  logic [1:0]       Op     = 2'b00;
  logic [WIDTH-1:0] input1 = '0;
  logic [WIDTH-1:0] input2 = '0;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivByZero;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             dbz;
    int               acc_cyc;
  } exp_t;

  exp_t exp_q[$];

  alu_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Op        (Op),
    .input1    (input1),
    .input2    (input2),
    .Busy      (Busy),
    .Done      (Done),
    .Hi        (Hi),
    .Lo        (Lo),
    .DivByZero (DivByZero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: track Busy run length and check every Done against the queue.
  logic busy_prev = 1'b0;
  int   busy_run  = 0;
  exp_t e_mon;

  always @(negedge clk) begin
    if (Busy) busy_run = busy_prev ? busy_run + 1 : 1;
    busy_prev = Busy;
    if (Done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        e_mon = exp_q.pop_front();
        chk({e_mon.name, " Hi"}, 32'(Hi), 32'(e_mon.hi));
        chk({e_mon.name, " Lo"}, 32'(Lo), 32'(e_mon.lo));
        chk({e_mon.name, " DivByZero"}, 32'(DivByZero), 32'(e_mon.dbz));
        chk({e_mon.name, " latency"}, 32'(cyc - e_mon.acc_cyc), 32'(WIDTH + 1));
        chk({e_mon.name, " busy_cycles"}, 32'(busy_run), 32'(WIDTH + 1));
        chk({e_mon.name, " busy_in_done"}, 32'(Busy), 32'(0));
      end
    end
  end

  // Wait for Busy=0 (IDLE or the DONE cycle), raise Start for one edge, queue
  // the expected result, then scramble the inputs to show they are not reused.
  task automatic issue(input string nm, input logic [1:0] op,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                       input logic ed);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (Busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (Busy) begin
      checks++;
      errors++;
      $display("FAIL %s accept_wait: Busy=1 after %0d cycles, expected 0", nm, n);
    end
    Op     = op;
    input1 = a;
    input2 = b;
    Start  = 1'b1;
    e.name    = nm;
    e.hi      = eh;
    e.lo      = el;
    e.dbz     = ed;
    e.acc_cyc = cyc + 1;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
    Start  = 1'b0;
    Op     = ~op;
    input1 = ~a;
    input2 = ~b;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, " Busy"}, 32'(Busy), 32'(0));
    chk({nm, " Done"}, 32'(Done), 32'(0));
    chk({nm, " Hi"}, 32'(Hi), 32'(0));
    chk({nm, " Lo"}, 32'(Lo), 32'(0));
    chk({nm, " DivByZero"}, 32'(DivByZero), 32'(0));
  endtask

  initial begin
    int n;
    #21;
    chk_zero_outputs("reset");
    rst_n = 1'b1;

    // Directed vectors; consecutive issues are accepted in the DONE cycle.
    issue("multu_13x11",  2'b00, 8'h0D, 8'h0B, 8'h00, 8'h8F, 1'b0);
    issue("mult_m3x5",    2'b01, 8'hFD, 8'h05, 8'hFF, 8'hF1, 1'b0);
    issue("mult_80x80",   2'b01, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
    issue("divu_200_7",   2'b10, 8'hC8, 8'h07, 8'h04, 8'h1C, 1'b0);
    issue("div_m7_2",     2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0);
    issue("div_80_ff",    2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    issue("divu_2a_0",    2'b10, 8'h2A, 8'h00, 8'h2A, 8'hFF, 1'b1);
    issue("multu_2x2",    2'b00, 8'h02, 8'h02, 8'h00, 8'h04, 1'b0);
    repeat (14) @(negedge clk);

    // Start pulse with different operands in the middle of RUN is ignored.
    issue("multu_ign",    2'b00, 8'h10, 8'h10, 8'h01, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    Op     = 2'b10;
    input1 = 8'h55;
    input2 = 8'h03;
    Start  = 1'b1;
    @(negedge clk);
    Start  = 1'b0;
    chk("mid_run_busy", 32'(Busy), 32'(1));

    issue("div_5_m2",     2'b11, 8'h05, 8'hFE, 8'h01, 8'hFE, 1'b0);

    // Short asynchronous reset in the middle of RUN discards the operation.
    issue("abort",        2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    rst_n = 1'b1;
    exp_q.delete(exp_q.size() - 1);
    repeat (14) @(negedge clk);

    issue("multu_ffxff",  2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);
    issue("mult_7fx81",   2'b01, 8'h7F, 8'h81, 8'hC0, 8'hFF, 1'b0);
    issue("div_80_0",     2'b11, 8'h80, 8'h00, 8'h80, 8'hFF, 1'b1);
    issue("multu_3x4",    2'b00, 8'h03, 8'h04, 8'h00, 8'h0C, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
    end
    repeat (15) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
